// File: rtl/memory_arbiter.sv
// Purpose: two-master round-robin arbiter serialising one read/write at a time onto a shared memory bus.
// Latency: request seen in IDLE at T -> strobe at T+1; write ack at T+2, read ack + data at T+2+MEM_LATENCY.
// Backpressure: masters hold read/write until their one-cycle ack; requests are not sampled outside IDLE.
module memory_arbiter #(
  parameter int MEM_LATENCY = 1  // cycles from memory_read strobe to valid read_data, 1..4
) (
  input  logic        clk,
  input  logic        reset,          // synchronous, active low
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_write_data,
  output logic [31:0] m0_read_data,
  output logic        m0_ack,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_write_data,
  output logic [31:0] m1_read_data,
  output logic        m1_ack,
  output logic        memory_read,
  output logic        memory_write,
  output logic [31:0] address,
  output logic [31:0] write_data,
  input  logic [31:0] read_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // WAIT is entered with cnt = MEM_LATENCY-1 and read_data is sampled when it reaches 0,
  // which lands exactly MEM_LATENCY cycles after the strobe.
  localparam logic [1:0] CNT_INIT = 2'(MEM_LATENCY - 1);

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;          // granted master id (0 or 1)
  logic        wr_q, wr_d;            // latched op: 1 = write, 0 = read
  logic        last_q, last_d;        // master served most recently
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] address_q, address_d;
  logic [31:0] write_data_q, write_data_d;
  logic [31:0] m0_read_data_q, m0_read_data_d;
  logic [31:0] m1_read_data_q, m1_read_data_d;

  logic        m0_req;
  logic        m1_req;
  logic        any_req;
  logic        gnt_sel;

  // Arbitration: a lone requester wins; on a tie the master not served last wins.
  always_comb begin
    m0_req  = m0_read | m0_write;
    m1_req  = m1_read | m1_write;
    any_req = m0_req | m1_req;
    gnt_sel = 1'b0;
    if (m0_req && m1_req) begin
      gnt_sel = ~last_q;
    end else begin
      gnt_sel = m1_req;
    end
  end

  // Next-state and datapath updates for the one-transaction-at-a-time FSM.
  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    wr_d           = wr_q;
    last_d         = last_q;
    cnt_d          = cnt_q;
    address_d      = address_q;
    write_data_d   = write_data_q;
    m0_read_data_d = m0_read_data_q;
    m1_read_data_d = m1_read_data_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ISSUE;
          gnt_d   = gnt_sel;
          last_d  = gnt_sel;
          // Write dominates when a master raises both read and write.
          if (gnt_sel) begin
            wr_d         = m1_write;
            address_d    = m1_address;
            write_data_d = m1_write_data;
          end else begin
            wr_d         = m0_write;
            address_d    = m0_address;
            write_data_d = m0_write_data;
          end
        end
      end
      ISSUE: begin
        if (wr_q) begin
          state_d = DONE;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end else begin
          state_d = DONE;
          // Only the granted master's capture register moves.
          if (gnt_q) begin
            m1_read_data_d = read_data;
          end else begin
            m0_read_data_d = read_data;
          end
        end
      end
      DONE: begin
        // Requests are deliberately ignored here; a held request restarts from IDLE.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      gnt_q          <= 1'b0;
      wr_q           <= 1'b0;
      last_q         <= 1'b1;   // master 0 wins the first tie
      cnt_q          <= 2'd0;
      address_q      <= 32'd0;
      write_data_q   <= 32'd0;
      m0_read_data_q <= 32'd0;
      m1_read_data_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      gnt_q          <= gnt_d;
      wr_q           <= wr_d;
      last_q         <= last_d;
      cnt_q          <= cnt_d;
      address_q      <= address_d;
      write_data_q   <= write_data_d;
      m0_read_data_q <= m0_read_data_d;
      m1_read_data_q <= m1_read_data_d;
    end
  end

  // Outputs are decoded purely from registered state, so they never depend on the live request lines.
  always_comb begin
    memory_read  = (state_q == ISSUE) && !wr_q;
    memory_write = (state_q == ISSUE) && wr_q;
    m0_ack       = (state_q == DONE) && !gnt_q;
    m1_ack       = (state_q == DONE) && gnt_q;
    busy         = (state_q != IDLE);
    address      = address_q;
    write_data   = write_data_q;
    m0_read_data = m0_read_data_q;
    m1_read_data = m1_read_data_q;
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Purpose: randomized + directed scoreboard bench for memory_arbiter at MEM_LATENCY 1 and 3.
// Latency: expectations carry request cycle; monitor checks strobe-to-ack and request-to-ack timing.
// Backpressure: drivers hold requests until ack and drop them in the ack cycle.
module tb_memory_arbiter;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    int          t0;     // request cycle when timing from an idle arbiter is checked, else -1
  } exp_t;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  logic        rst_n  [2];
  logic        rd_i   [2][2];
  logic        wr_i   [2][2];
  logic [31:0] ad_i   [2][2];
  logic [31:0] wd_i   [2][2];
  logic [31:0] rdat_o [2][2];
  logic        ack_o  [2][2];
  logic        mr_o   [2];
  logic        mw_o   [2];
  logic        busy_o [2];
  logic [31:0] addr_o [2];
  logic [31:0] wdat_o [2];
  logic [31:0] mem_rd [2];
  bit          rst_pos[2];

  exp_t        sbq    [2][2][$];
  int          ack_log[2][$];

  // monitor bookkeeping
  int          n_str  [2];
  int          st_cyc [2];
  logic        st_wr  [2];
  logic [31:0] st_addr[2];
  logic [31:0] st_wd  [2];
  logic [31:0] hold   [2][2];
  bit          idle_chk[2];

  // memory model bookkeeping
  int          cd[2];
  logic [31:0] pv[2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    memory_arbiter #(.MEM_LATENCY(gi == 0 ? 1 : 3)) u_dut (
      .clk          (clk),
      .reset        (rst_n[gi]),
      .m0_read      (rd_i[gi][0]),
      .m0_write     (wr_i[gi][0]),
      .m0_address   (ad_i[gi][0]),
      .m0_write_data(wd_i[gi][0]),
      .m0_read_data (rdat_o[gi][0]),
      .m0_ack       (ack_o[gi][0]),
      .m1_read      (rd_i[gi][1]),
      .m1_write     (wr_i[gi][1]),
      .m1_address   (ad_i[gi][1]),
      .m1_write_data(wd_i[gi][1]),
      .m1_read_data (rdat_o[gi][1]),
      .m1_ack       (ack_o[gi][1]),
      .memory_read  (mr_o[gi]),
      .memory_write (mw_o[gi]),
      .address      (addr_o[gi]),
      .write_data   (wdat_o[gi]),
      .read_data    (mem_rd[gi]),
      .busy         (busy_o[gi])
    );
  end

  always #5 clk = ~clk;

  function automatic int lat(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Memory contents are a fixed function of address, so read results do not depend on grant order.
  function automatic logic [31:0] memf(logic [31:0] a);
    if (a == 32'h40) return 32'h1234_5678;
    return (a * 32'h9E37_79B1) ^ 32'hC3C3_0000;
  endfunction

  // Cycle counter and the reset level each DUT sampled at this edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) rst_pos[i] = rst_n[i];
  end

  // Memory: data valid only in the cycle exactly lat cycles after the read strobe, garbage otherwise.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      bit deliver;
      deliver = 1'b0;
      if (cd[i] > 0) begin
        cd[i] = cd[i] - 1;
        if (cd[i] == 0) deliver = 1'b1;
      end
      mem_rd[i] = deliver ? pv[i] : (32'hBAD0_0000 ^ 32'(cyc));
      if (mr_o[i]) begin
        cd[i] = lat(i);
        pv[i] = memf(addr_o[i]);
      end
    end
  end

  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d cyc%0d: got %h want %h", nm, i, cyc, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst_pos[i]) begin
          chk("rst_mem_read", i, 32'(mr_o[i]), 0);
          chk("rst_mem_write", i, 32'(mw_o[i]), 0);
          chk("rst_busy", i, 32'(busy_o[i]), 0);
          chk("rst_ack0", i, 32'(ack_o[i][0]), 0);
          chk("rst_ack1", i, 32'(ack_o[i][1]), 0);
          chk("rst_address", i, addr_o[i], 0);
          chk("rst_write_data", i, wdat_o[i], 0);
          chk("rst_rdata0", i, rdat_o[i][0], 0);
          chk("rst_rdata1", i, rdat_o[i][1], 0);
          hold[i][0] = 32'd0;
          hold[i][1] = 32'd0;
          n_str[i] = 0;
          idle_chk[i] = 1'b0;
        end else begin
          if (idle_chk[i]) begin
            chk("busy_after_ack", i, 32'(busy_o[i]), 0);
            idle_chk[i] = 1'b0;
          end
          if (mr_o[i] || mw_o[i]) begin
            chk("strobe_exclusive", i, 32'(mr_o[i] & mw_o[i]), 0);
            n_str[i]++;
            st_cyc[i]  = cyc;
            st_wr[i]   = mw_o[i];
            st_addr[i] = addr_o[i];
            st_wd[i]   = wdat_o[i];
          end
          if (ack_o[i][0] || ack_o[i][1])
            chk("ack_exclusive", i, 32'(ack_o[i][0] & ack_o[i][1]), 0);
          for (int m = 0; m < 2; m++) begin
            if (ack_o[i][m]) begin
              if (sbq[i][m].size() == 0) begin
                chk("unexpected_ack", i, 32'(m + 1), 0);
              end else begin
                e = sbq[i][m].pop_front();
                chk("strobes_per_txn", i, 32'(n_str[i]), 1);
                chk("op_kind", i, 32'(st_wr[i]), 32'(e.wr));
                chk("bus_address", i, st_addr[i], e.addr);
                if (e.wr) chk("bus_write_data", i, st_wd[i], e.wd);
                chk("strobe_to_ack", i, 32'(cyc - st_cyc[i]), 32'(e.wr ? 1 : lat(i) + 1));
                if (e.t0 >= 0)
                  chk("req_to_ack", i, 32'(cyc), 32'(e.t0 + (e.wr ? 2 : 2 + lat(i))));
                chk("busy_in_ack", i, 32'(busy_o[i]), 1);
                if (!e.wr) hold[i][m] = memf(e.addr);
                chk("rdata_m0", i, rdat_o[i][0], hold[i][0]);
                chk("rdata_m1", i, rdat_o[i][1], hold[i][1]);
              end
              n_str[i] = 0;
              idle_chk[i] = 1'b1;
              ack_log[i].push_back(m);
            end
          end
        end
      end
    end
  endtask

  task automatic wait_ack(int i, int m, output bit got);
    got = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (ack_o[i][m]) begin
        got = 1'b1;
        break;
      end
    end
    chk("ack_timeout", i, 32'(got), 1);
  endtask

  task automatic reset_dut(int i, int n);
    @(posedge clk); #1;
    rst_n[i] = 1'b0;
    for (int m = 0; m < 2; m++) begin
      rd_i[i][m] = 1'b0;
      wr_i[i][m] = 1'b0;
    end
    repeat (n) @(posedge clk);
    #1;
    rst_n[i] = 1'b1;
  endtask

  // One transaction: raise, wait for ack, drop in the ack cycle.
  task automatic req(int i, int m, bit r, bit w, logic [31:0] a, logic [31:0] d, bit chk_t);
    exp_t e;
    bit   got;
    @(posedge clk); #1;
    e.wr   = w;
    e.addr = a;
    e.wd   = d;
    e.t0   = chk_t ? cyc : -1;
    sbq[i][m].push_back(e);
    rd_i[i][m] = r;
    wr_i[i][m] = w;
    ad_i[i][m] = a;
    wd_i[i][m] = d;
    wait_ack(i, m, got);
    rd_i[i][m] = 1'b0;
    wr_i[i][m] = 1'b0;
  endtask

  // Read held continuously across n transactions.
  task automatic hold_rd(int i, int m, logic [31:0] a, int n);
    exp_t e;
    bit   got;
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      e.wr = 1'b0; e.addr = a; e.wd = 32'd0; e.t0 = -1;
      sbq[i][m].push_back(e);
    end
    rd_i[i][m] = 1'b1;
    wr_i[i][m] = 1'b0;
    ad_i[i][m] = a;
    for (int k = 0; k < n; k++) begin
      wait_ack(i, m, got);
      if (!got) break;
    end
    rd_i[i][m] = 1'b0;
  endtask

  task automatic rnd_master(int i, int m, int n);
    int          op;
    logic [31:0] a;
    logic [31:0] d;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      op = $urandom_range(0, 3);
      a  = $urandom & 32'h0000_FFFC;
      d  = $urandom;
      req(i, m, op != 2, op >= 2, a, d, 1'b0);
    end
  endtask

  task automatic run_inst(int i);
    reset_dut(i, 2);
    // single write, then uncontended read, then read+write collapsing to a write
    req(i, 0, 1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1);
    req(i, 1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1);
    req(i, 0, 1'b1, 1'b1, 32'h200, 32'hA5A5_A5A5, 1'b1);

    // continuous contention straight after reset
    reset_dut(i, 2);
    ack_log[i].delete();
    fork
      hold_rd(i, 0, 32'h0, 2);
      hold_rd(i, 1, 32'h4, 2);
    join
    chk("contend_count", i, 32'(ack_log[i].size()), 4);
    for (int k = 0; k < ack_log[i].size(); k++)
      chk("contend_order", i, 32'(ack_log[i][k]), 32'(k % 2));

    if (i == 1) begin
      // reset in the second WAIT cycle of an m0 read aborts it without an ack
      @(posedge clk); #1;
      rd_i[i][0] = 1'b1;
      ad_i[i][0] = 32'h80;
      repeat (3) @(posedge clk);
      #1;
      rst_n[i] = 1'b0;
      rd_i[i][0] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n[i] = 1'b1;
      ack_log[i].delete();
      fork
        req(i, 0, 1'b0, 1'b1, 32'h300, 32'h1111_1111, 1'b0);
        req(i, 1, 1'b0, 1'b1, 32'h304, 32'h2222_2222, 1'b0);
      join
      chk("tie_count", i, 32'(ack_log[i].size()), 2);
      if (ack_log[i].size() > 0)
        chk("tie_winner_m0", i, 32'(ack_log[i][0]), 0);
    end

    fork
      rnd_master(i, 0, 15);
      rnd_master(i, 1, 15);
    join
    repeat (4) @(posedge clk);
    chk("drain_m0", i, 32'(sbq[i][0].size()), 0);
    chk("drain_m1", i, 32'(sbq[i][1].size()), 0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i]  = 1'b0;
      mem_rd[i] = 32'd0;
      cd[i]     = 0;
      pv[i]     = 32'd0;
      n_str[i]  = 0;
      idle_chk[i] = 1'b0;
      for (int m = 0; m < 2; m++) begin
        rd_i[i][m] = 1'b0;
        wr_i[i][m] = 1'b0;
        ad_i[i][m] = 32'd0;
        wd_i[i][m] = 32'd0;
        hold[i][m] = 32'd0;
      end
    end
    fork
      monitor();
      begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: bench exceeded cycle budget");
        $fatal(1);
      end
    join_none
    fork
      run_inst(0);
      run_inst(1);
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-master arbiter that shares the single memory bus between the core's load/store/fetch port (master 0) and an auxiliary requester (master 1, e.g. a loader or debug port). It sits between the requesters and the memory. It serializes one transaction at a time, uses round-robin on contention, and gives each master a registered acknowledge plus read-data return. The memory side uses the same bus signals the core drives: `memory_read`, `memory_write`, `address`, `write_data`, `read_data`.

## Interface
- `MEM_LATENCY`, default 1: cycles from the `memory_read` strobe until `read_data` is valid. Legal range 1..4.
- `clk`  in  1  system clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-low reset
- `m0_read`, `m1_read`  in  1  read request, held until ack
- `m0_write`, `m1_write`  in  1  write request, held until ack
- `m0_address`, `m1_address`  in  32  request address, stable while requesting
- `m0_write_data`, `m1_write_data`  in  32  write data, stable while requesting
- `m0_read_data`, `m1_read_data`  out  32  captured read data, held until that master's next read completes
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse
- `memory_read`  out  1  read strobe to memory
- `memory_write`  out  1  write strobe to memory
- `address`  out  32  memory address (latched request)
- `write_data`  out  32  memory write data (latched request)
- `read_data`  in  32  memory read data
- `busy`  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - A master is requesting when its `read` or `write` is high.
  - If exactly one master requests, grant it.
  - If both request, grant the master not served last (round-robin pointer `last`).
  - On grant, latch master id, op, `address` and `write_data`; update `last`; go to ISSUE.
  - With no request, stay in IDLE.
- **ISSUE**
  - Assert exactly one of `memory_read` or `memory_write` for one cycle.
  - A write goes to DONE.
  - A read goes to WAIT and loads `cnt` = MEM_LATENCY-1.
- **WAIT**
  - While `cnt` is nonzero, decrement it.
  - When `cnt` is 0, capture `read_data` into the granted master's `read_data` register and go to DONE.
- **DONE**
  - Pulse the granted master's ack.
  - Requests are ignored in this state.
  - Return to IDLE.
- If a master has both `read` and `write` high, the request is a write and the read is ignored.
- `address` and `write_data` always reflect the last latched request. They change only on grant.
- Strobes are 0 outside ISSUE. An ack is never asserted for the non-granted master.
- The non-granted master's `read_data` register is unchanged.

## Timing
- Reset values:
  - State IDLE; `last` = 1, so master 0 wins the first tie.
  - All strobes, acks and `busy` are 0.
  - `address`, `write_data`, `m0_read_data` and `m1_read_data` are 0; `cnt` is 0.
- Reset is sampled on the clock edge. Reset low mid-transaction aborts it: strobes and ack are 0 from the next cycle, no ack is issued, and captured data is cleared.
- Request seen in IDLE at cycle T:
  - ISSUE at T+1, with the strobe high in T+1.
  - Write: ack at T+2.
  - Read: WAIT occupies T+2..T+1+MEM_LATENCY. `read_data` is sampled at the end of cycle T+1+MEM_LATENCY, which is the cycle MEM_LATENCY cycles after the strobe. Ack and valid `mX_read_data` appear at T+2+MEM_LATENCY.
- Throughput: a write takes 3 cycles and a read takes 3+MEM_LATENCY cycles, IDLE cycle included.
- Back-to-back requests:
  - A request still held in the cycle after ack is treated as a new transaction.
  - A requester that wants exactly one access must drop its request in the ack cycle.
- Under continuous contention, grants alternate strictly: m0, m1, m0, and so on.
- A request raised by the losing master while a transaction is in flight is served next, because of round-robin.

## Test plan
- Reset then single write:
  - Stimulus: reset low 2 cycles, then high; m0 writes 0xDEADBEEF to 0x100.
  - Required: `memory_write` high exactly one cycle with `address`=0x100 and `write_data`=0xDEADBEEF; `m0_ack` pulses 2 cycles after the request is seen; all outputs are 0 during reset.
- Read latency, MEM_LATENCY=1 and MEM_LATENCY=3:
  - Stimulus: m1 reads 0x40; the memory model returns 0x12345678 after the configured latency.
  - Required: `m1_ack` arrives at T+3 and T+5 respectively, with `m1_read_data`=0x12345678; `m0_read_data` unchanged.
- Simultaneous requests after reset:
  - Stimulus: m0 reads 0x0 and m1 reads 0x4, both held continuously.
  - Required: grant order m0, m1, m0, m1; acks never overlap; `address` alternates 0x0, 0x4.
- Read and write both high:
  - Stimulus: m0 asserts read and write with data 0xA5A5A5A5.
  - Required: one `memory_write` with 0xA5A5A5A5; `memory_read` stays 0.
- Reset mid-read, MEM_LATENCY=3:
  - Stimulus: reset low in the second WAIT cycle.
  - Required: no `m0_ack` is issued; `busy`=0 and all strobes 0 the next cycle; after reset release, the first tie is won by m0.
